// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue path: ALU op codes, RV32I
// opcode/funct fields and the issue controller state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Only add and sub produce meaningful carry/overflow.
    function automatic logic has_flags(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational RV32I decode of OP / OP-IMM instructions into ALU op and
// operands; anything the ALU cannot execute is flagged illegal.
module alu_instr_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [3:0]  op,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [4:0]  rd,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_rs_idx;

    assign opcode        = instr[6:0];
    assign f3            = instr[14:12];
    assign f7            = instr[31:25];
    assign rd            = instr[11:7];
    assign unused_rs_idx = ^instr[19:15];

    always_comb begin
        op      = ALU_ADD;
        a       = rs1;
        b       = rs2;
        illegal = 1'b0;
        if (opcode == OPC_OP) begin
            if (f7 == F7_BASE) begin
                case (f3)
                    F3_ADD:  op = ALU_ADD;
                    F3_AND:  op = ALU_AND;
                    F3_XOR:  op = ALU_XOR;
                    F3_OR:   op = ALU_OR;
                    F3_SLL:  op = ALU_SLL;
                    F3_SR:   op = ALU_SRL;
                    F3_SLT:  op = ALU_SLT;
                    default: op = ALU_SLTU;
                endcase
            end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                op = ALU_SUB;
            end else begin
                // sra and unknown funct7 have no ALU op
                illegal = 1'b1;
            end
        end else if (opcode == OPC_OP_IMM) begin
            b = {{20{instr[31]}}, instr[31:20]};
            case (f3)
                F3_ADD:  op = ALU_ADD;
                F3_AND:  op = ALU_AND;
                F3_XOR:  op = ALU_XOR;
                F3_OR:   op = ALU_OR;
                F3_SLT:  op = ALU_SLT;
                F3_SLTU: op = ALU_SLTU;
                F3_SLL: begin
                    op      = ALU_SLL;
                    b       = {27'd0, instr[24:20]};
                    illegal = (f7 != F7_BASE);
                end
                default: begin
                    op      = ALU_SRL;
                    b       = {27'd0, instr[24:20]};
                    illegal = (f7 != F7_BASE);
                end
            endcase
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction, drives the ALU for ALU_LAT
// cycles, captures the result and returns it over a valid/ready response.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_instr,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        alu_valid,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_rd,
    output logic        rsp_carry,
    output logic        rsp_overflow,
    output logic        rsp_zero,
    output logic        rsp_illegal
);

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] res_q, res_d;
    logic        carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, ill_q, ill_d;

    logic [3:0]  dec_op;
    logic [31:0] dec_a, dec_b;
    logic [4:0]  dec_rd;
    logic        dec_ill;
    logic        accept, last_cyc;

    alu_instr_decode u_dec (
        .instr   (req_instr),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .op      (dec_op),
        .a       (dec_a),
        .b       (dec_b),
        .rd      (dec_rd),
        .illegal (dec_ill)
    );

    assign accept   = (state_q == ST_IDLE) && req_valid;
    assign last_cyc = (state_q == ST_ISSUE) && (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = dec_ill ? ST_RESP : ST_ISSUE;
            ST_ISSUE: if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        alu_valid = (state_q == ST_ISSUE);
        rsp_valid = (state_q == ST_RESP);
    end

    // Operand registers only load on a legal accept so the ALU inputs stay
    // quiet between ops; response registers load on accept or capture.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        if (accept) begin
            rd_d = dec_rd;
            if (dec_ill) begin
                res_d   = 32'd0;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
                zero_d  = 1'b0;
                ill_d   = 1'b1;
            end else begin
                a_d   = dec_a;
                b_d   = dec_b;
                op_d  = dec_op;
                cnt_d = CNT_INIT;
                ill_d = 1'b0;
            end
        end else if (last_cyc) begin
            res_d   = alu_result;
            carry_d = has_flags(op_q) & alu_carryout;
            ovf_d   = has_flags(op_q) & alu_overflow;
            zero_d  = (alu_result == 32'd0);
        end else if (state_q == ST_ISSUE) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ALU_ADD;
            cnt_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign rsp_result   = res_q;
    assign rsp_rd       = rd_q;
    assign rsp_carry    = carry_q;
    assign rsp_overflow = ovf_q;
    assign rsp_zero     = zero_q;
    assign rsp_illegal  = ill_q;

endmodule
